// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the FU writeback packet and
// core-level sizing constants.
package wb_arbiter_pkg;

    localparam int ROB_W      = 6;
    localparam int EPOCH_W    = 2;
    localparam int N_WB_PORTS = 4;

    typedef struct packed {
        logic [ROB_W-1:0]   rob_idx;
        logic [EPOCH_W-1:0] epoch;
        logic               is_branch;
        logic               mispredict;
        logic [31:0]        result;
    } fu_wb_t;

    // A packet that should jump the round-robin queue to start recovery early.
    function automatic logic is_mispredict(input fu_wb_t pkt);
        return pkt.is_branch && pkt.mispredict;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: grants the first requester at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any_gnt
);

    logic [W-1:0] idx;

    // Modulo-N add that also works when N is not a power of two.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
        logic [W:0] s;
        s = {1'b0, base} + (W+1)'(off);
        if (s >= (W+1)'(N)) s = s - (W+1)'(N);
        return s[W-1:0];
    endfunction

    // Scan requesters starting from ptr; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = wrap_add(ptr, k);
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single ROB writeback port between N_FU functional units.
// Round-robin selection, optional priority for mispredicted branches, and one
// registered output stage (1-cycle latency, full throughput under wb_ready).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_FU    = N_WB_PORTS,
    parameter int FU_W    = $clog2(N_FU),
    parameter int BR_PRIO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_FU-1:0] fu_valid,
    output logic [N_FU-1:0] fu_ready,
    input  fu_wb_t          fu_pkt [N_FU],
    output logic            wb_valid,
    input  logic            wb_ready,
    output fu_wb_t          wb_pkt,
    output logic [FU_W-1:0] wb_src,
    input  logic            flush_valid
);

    logic [N_FU-1:0] br_req;
    logic [N_FU-1:0] req_masked;
    logic [N_FU-1:0] gnt;
    logic [FU_W-1:0] gnt_idx;
    logic [FU_W-1:0] rr_ptr;
    logic            any_gnt;
    logic            slot_free;
    logic            accept;

    // Requests that carry a branch mispredict; these may pre-empt everyone else.
    always_comb begin
        br_req = '0;
        for (int i = 0; i < N_FU; i++) begin
            br_req[i] = fu_valid[i] && is_mispredict(fu_pkt[i]);
        end
    end

    assign req_masked = ((BR_PRIO != 0) && (|br_req)) ? br_req : fu_valid;

    rr_arbiter #(
        .N (N_FU),
        .W (FU_W)
    ) u_rr (
        .req     (req_masked),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // The slot refills in the same cycle it drains, so no bubble under steady wb_ready.
    assign slot_free = !wb_valid || wb_ready;
    assign fu_ready  = (slot_free && !flush_valid && !rst) ? gnt : '0;
    assign accept    = any_gnt && slot_free && !flush_valid && !rst;

    // Output register and round-robin pointer; reset beats flush, flush beats accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_pkt   <= '0;
            wb_src   <= '0;
            rr_ptr   <= '0;
        end else if (flush_valid) begin
            wb_valid <= 1'b0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_pkt   <= fu_pkt[gnt_idx];
            wb_src   <= gnt_idx;
            rr_ptr   <= (gnt_idx == FU_W'(N_FU - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-scenario tasks plus a scoreboard of
// accepted packets that is checked when the ROB consumes them.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fu_valid;
    logic [3:0] fu_ready;
    fu_wb_t     fu_pkt [4];
    logic       wb_valid;
    logic       wb_ready;
    fu_wb_t     wb_pkt;
    logic [1:0] wb_src;
    logic       flush_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side reference state
    fu_wb_t exp_pkt_q[$];
    int     exp_src_q[$];
    int     m_ptr    = 0;
    bit     m_valid  = 0;
    int     last_acc = -1;
    bit     rand_br  = 0;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_pkt      (fu_pkt),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_pkt      (wb_pkt),
        .wb_src      (wb_src),
        .flush_valid (flush_valid)
    );

    always #5 clk = ~clk;

    function automatic int model_winner();
        logic [3:0] br;
        logic [3:0] el;
        for (int i = 0; i < 4; i++)
            br[i] = fu_valid[i] && fu_pkt[i].is_branch && fu_pkt[i].mispredict;
        el = (br != 4'b0) ? br : fu_valid;
        for (int k = 0; k < 4; k++)
            if (el[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    // One clock: check combinational outputs against the model, update the
    // scoreboard, advance to just after the next posedge.
    task automatic step(input bit chk_state);
        int         w;
        logic [3:0] er;
        fu_wb_t     ep;
        int         es;
        #1;
        w  = model_winner();
        er = 4'b0;
        if (!rst && !flush_valid && (!m_valid || wb_ready) && w >= 0) er[w] = 1'b1;
        n_checks++;
        if (fu_ready !== er) begin
            n_fail++;
            $display("FAIL fu_ready: got %b expected %b at %0t", fu_ready, er, $time);
        end
        if (chk_state) begin
            n_checks++;
            if (wb_valid !== m_valid) begin
                n_fail++;
                $display("FAIL wb_valid: got %b expected %b at %0t", wb_valid, m_valid, $time);
            end
        end
        last_acc = -1;
        if (rst) begin
            exp_pkt_q.delete();
            exp_src_q.delete();
            m_valid = 0;
            m_ptr   = 0;
        end else if (flush_valid) begin
            if (m_valid && exp_pkt_q.size() > 0) begin
                void'(exp_pkt_q.pop_front());
                void'(exp_src_q.pop_front());
            end
            m_valid = 0;
        end else begin
            if (m_valid && wb_ready) begin
                n_checks++;
                if (exp_pkt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: output consumed with nothing expected at %0t", $time);
                end else begin
                    ep = exp_pkt_q.pop_front();
                    es = exp_src_q.pop_front();
                    if (wb_pkt !== ep || int'(wb_src) != es) begin
                        n_fail++;
                        $display("FAIL wb_out: got src %0d pkt %h expected src %0d pkt %h at %0t",
                                 wb_src, wb_pkt, es, ep, $time);
                    end
                end
                m_valid = 0;
            end
            if (er != 4'b0) begin
                exp_pkt_q.push_back(fu_pkt[w]);
                exp_src_q.push_back(w);
                m_ptr    = (w + 1) % 4;
                m_valid  = 1;
                last_acc = w;
            end
        end
        @(posedge clk);
        #1;
        // Accepted FU now presents its next packet.
        if (last_acc >= 0) begin
            fu_pkt[last_acc].result = fu_pkt[last_acc].result + 32'h100;
            if (rand_br) begin
                fu_pkt[last_acc].is_branch  = ($urandom_range(0, 3) == 0);
                fu_pkt[last_acc].mispredict = ($urandom_range(0, 1) == 0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fu_valid = 4'b1111; wb_ready = 1'b1; flush_valid = 1'b0;
        step(0);
        step(1);
        n_checks++;
        if (wb_valid !== 1'b0 || wb_pkt !== fu_wb_t'(0) || wb_src !== 2'd0 || fu_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b pkt=%h src=%0d rdy=%b required 0/0/0/0",
                     wb_valid, wb_pkt, wb_src, fu_ready);
        end
        rst = 1'b0;
        step(1);
        n_checks++;
        if (last_acc != 0 || wb_valid !== 1'b1 || wb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got acc=%0d v=%b src=%0d required 0/1/0",
                     last_acc, wb_valid, wb_src);
        end
    endtask

    task automatic test_round_robin();
        int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        fu_valid = 4'b0000; step(1);
        fu_valid = 4'b1000; step(1);
        fu_valid = 4'b0000; step(1);
        fu_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step(1);
            n_checks++;
            if (wb_valid !== 1'b1 || int'(wb_src) != seq[k]) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got v=%b src=%0d required 1/%0d", k, wb_valid, wb_src, seq[k]);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        fu_valid = 4'b0100; step(1);
        fu_valid = 4'b0101;
        step(1);
        n_checks++;
        if (last_acc != 0 || dut.rr_ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL sparse_first: got acc=%0d ptr=%0d required 0/1", last_acc, dut.rr_ptr);
        end
        step(1);
        n_checks++;
        if (last_acc != 2 || dut.rr_ptr !== 2'd3) begin
            n_fail++;
            $display("FAIL sparse_second: got acc=%0d ptr=%0d required 2/3", last_acc, dut.rr_ptr);
        end
        fu_valid = 4'b0000; step(1);
    endtask

    task automatic test_backpressure();
        fu_pkt[3].rob_idx = 6'd5;
        fu_valid = 4'b1000; step(1);
        wb_ready = 1'b0; fu_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step(1);
            n_checks++;
            if (wb_valid !== 1'b1 || wb_pkt.rob_idx !== 6'd5 || wb_src !== 2'd3) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b rob=%0d src=%0d required 1/5/3",
                         k, wb_valid, wb_pkt.rob_idx, wb_src);
            end
        end
        wb_ready = 1'b1;
        step(1);
        n_checks++;
        if (wb_valid !== 1'b1 || wb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b src=%0d required 1/0", wb_valid, wb_src);
        end
        fu_valid = 4'b0000; step(1);
    endtask

    task automatic test_br_prio();
        fu_valid = 4'b1000; step(1);
        fu_valid = 4'b0000; step(1);
        fu_pkt[2].is_branch = 1'b1; fu_pkt[2].mispredict = 1'b1;
        fu_valid = 4'b0101;
        step(1);
        n_checks++;
        if (last_acc != 2 || dut.rr_ptr !== 2'd3 || wb_src !== 2'd2) begin
            n_fail++;
            $display("FAIL br_prio_first: got acc=%0d ptr=%0d src=%0d required 2/3/2",
                     last_acc, dut.rr_ptr, wb_src);
        end
        fu_pkt[2].is_branch = 1'b0; fu_pkt[2].mispredict = 1'b0;
        step(1);
        n_checks++;
        if (last_acc != 0) begin
            n_fail++;
            $display("FAIL br_prio_next: got acc=%0d required 0", last_acc);
        end
        fu_valid = 4'b0000; step(1);
    endtask

    task automatic test_flush();
        fu_valid = 4'b1111; step(1);
        wb_ready = 1'b0; flush_valid = 1'b1;
        step(1);
        n_checks++;
        if (wb_valid !== 1'b0 || dut.rr_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL flush: got v=%b ptr=%0d required 0/2", wb_valid, dut.rr_ptr);
        end
        flush_valid = 1'b0;
        step(1);
        n_checks++;
        if (last_acc != 2) begin
            n_fail++;
            $display("FAIL flush_resume: got acc=%0d required 2", last_acc);
        end
        wb_ready = 1'b1; fu_valid = 4'b0000; step(1);
    endtask

    task automatic test_back_to_back();
        rand_br = 1;
        for (int k = 0; k < 80; k++) begin
            fu_valid    = 4'($urandom_range(0, 15));
            wb_ready    = ($urandom_range(0, 3) != 0);
            flush_valid = ($urandom_range(0, 15) == 0);
            step(1);
        end
        rand_br = 0; flush_valid = 1'b0; fu_valid = 4'b0000; wb_ready = 1'b1;
        step(1);
        n_checks++;
        if (exp_pkt_q.size() != 0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got pending=%0d v=%b required 0/0", exp_pkt_q.size(), wb_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            fu_pkt[i]         = '0;
            fu_pkt[i].rob_idx = 6'(i + 1);
            fu_pkt[i].result  = 32'hA000 + 32'(i);
        end
        rst = 1'b1; fu_valid = 4'b0; wb_ready = 1'b0; flush_valid = 1'b0;
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_br_prio();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
